// File: rtl/knn_query_sequencer.sv
// Query front-end for the KNN classifier core: byte-pair FIFO, single-query launch FSM, watchdog.
// Optional statistics counters are compiled in with KNN_QUERY_STATS_EN.
module knn_query_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       cls_x,
  output logic [7:0]       cls_y,
  output logic             cls_start,
  input  logic             cls_done,
  input  logic [1:0]       cls_class,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_class,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err,
  output logic             busy
`ifdef KNN_QUERY_STATS_EN
  ,
  output logic [15:0]      stat_count,
  output logic [7:0]       stat_err,
  output logic [9:0]       stat_last_lat
`endif
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic               phase_q, phase_d;
  logic [7:0]         x_hold_q, x_hold_d;
  logic [15:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]  count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic [7:0]         cls_x_q, cls_x_d, cls_y_q, cls_y_d;
  logic               cls_start_q, cls_start_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               res_valid_q, res_valid_d;
  logic [1:0]         res_class_q, res_class_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_err_q, res_err_d;
  logic               busy_q, busy_d;
  logic               accept, push, pop, wait_exit, timeout_hit;

`ifdef KNN_QUERY_STATS_EN
  logic [15:0] stat_count_q, stat_count_d;
  logic [7:0]  stat_err_q, stat_err_d;
  logic [9:0]  stat_last_lat_q, stat_last_lat_d;
`endif

  // Next-state and output computation
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    x_hold_d    = x_hold_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cls_x_d     = cls_x_q;
    cls_y_d     = cls_y_q;
    cls_start_d = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    pop         = 1'b0;
    wait_exit   = 1'b0;
    timeout_hit = 1'b0;

    accept = in_valid && in_ready_q;
    push   = accept && phase_q;
    if (accept) begin
      phase_d = !phase_q;
      if (!phase_q) x_hold_d = in_data;
    end

    // Counter reads 0 in LAUNCH and k in the k-th WAIT cycle
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop         = 1'b1;
          cls_x_d     = mem_q[rd_ptr_q][15:8];
          cls_y_d     = mem_q[rd_ptr_q][7:0];
          cls_start_d = 1'b1;
          wait_cnt_d  = '0;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (cls_done) begin
          wait_exit   = 1'b1;
          res_class_d = cls_class;
          res_err_d   = 1'b0;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT)) begin
          wait_exit   = 1'b1;
          timeout_hit = 1'b1;
          res_class_d = 2'd0;
          res_err_d   = 1'b1;
        end
        if (wait_exit) begin
          res_valid_d = 1'b1;
          res_tag_d   = tag_q;
          tag_d       = tag_q + TAG_W'(1);
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d    = count_q + FILL_W'(push) - FILL_W'(pop);
    in_ready_d = (count_d != FILL_W'(DEPTH));
    busy_d     = (state_d != S_IDLE) || (count_d != '0);

`ifdef KNN_QUERY_STATS_EN
    stat_count_d    = stat_count_q;
    stat_err_d      = stat_err_q;
    stat_last_lat_d = stat_last_lat_q;
    if (wait_exit) begin
      if (stat_count_q != 16'hFFFF) stat_count_d = stat_count_q + 16'd1;
      if (timeout_hit && (stat_err_q != 8'hFF)) stat_err_d = stat_err_q + 8'd1;
      stat_last_lat_d = 10'(wait_cnt_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      x_hold_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      cls_x_q     <= '0;
      cls_y_q     <= '0;
      cls_start_q <= 1'b0;
      wait_cnt_q  <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      x_hold_q    <= x_hold_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      cls_x_q     <= cls_x_d;
      cls_y_q     <= cls_y_d;
      cls_start_q <= cls_start_d;
      wait_cnt_q  <= wait_cnt_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {x_hold_q, in_data};
  end

`ifdef KNN_QUERY_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_count_q    <= '0;
      stat_err_q      <= '0;
      stat_last_lat_q <= '0;
    end else begin
      stat_count_q    <= stat_count_d;
      stat_err_q      <= stat_err_d;
      stat_last_lat_q <= stat_last_lat_d;
    end
  end

  assign stat_count    = stat_count_q;
  assign stat_err      = stat_err_q;
  assign stat_last_lat = stat_last_lat_q;
`endif

  assign in_ready  = in_ready_q;
  assign cls_x     = cls_x_q;
  assign cls_y     = cls_y_q;
  assign cls_start = cls_start_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Randomized bench for knn_query_sequencer: a transaction/timestamp model predicts every output each cycle.
module tb_knn_query_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 40;
  localparam int TAG_W   = 4;

  logic clk, rst, in_valid, in_ready, cls_start, cls_done, res_valid, res_ready, res_err, busy;
  logic [7:0] in_data, cls_x, cls_y;
  logic [1:0] cls_class, res_class;
  logic [TAG_W-1:0] res_tag;

  knn_query_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cls_x(cls_x), .cls_y(cls_y), .cls_start(cls_start), .cls_done(cls_done),
    .cls_class(cls_class), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_tag(res_tag), .res_err(res_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] x; logic [7:0] y; int c; } launch_t;
  typedef struct { logic [1:0] cls; logic [TAG_W-1:0] tag; logic err; int c; } res_t;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int vprob = 100, rprob = 100;
  bit hold_ready = 0, spur = 0, prev_rv = 0;
  logic [7:0] byte_q[$];
  int lat_q[$];
  logic [1:0] dcls_q[$];
  launch_t launch_log[$];
  res_t res_log[$];

  // Reference model: buffered pairs, one in-flight query described by timestamps
  logic [15:0] m_q[$];
  bit m_phase, m_act;
  logic [7:0] m_xh, m_cx, m_cy;
  int m_tag, m_lc, m_rc, m_lat, m_idle_from, m_rtag;
  logic [1:0] m_dcls, m_cls;
  bit m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete(); m_phase = 0; m_act = 0; m_xh = 0; m_cx = 0; m_cy = 0;
    m_tag = 0; m_lc = 0; m_rc = -1; m_lat = 0; m_idle_from = 0; m_rtag = 0;
    m_dcls = 0; m_cls = 0; m_err = 0; prev_rv = 0;
  endtask

  task automatic capture(input logic [1:0] c, input bit e);
    m_rc = cyc + 1; m_cls = c; m_err = e; m_rtag = m_tag;
    m_tag = (m_tag + 1) % (1 << TAG_W);
  endtask

  task automatic step();
    bit waiting, rv, exp_rdy;
    logic [15:0] pr;
    @(posedge clk); cyc++; #1;
    in_valid  = (byte_q.size() != 0) && ($urandom_range(99) < 32'(vprob));
    in_data   = in_valid ? byte_q[0] : 8'($urandom);
    res_ready = !hold_ready && ($urandom_range(99) < 32'(rprob));
    waiting   = m_act && (m_rc < 0) && (cyc > m_lc);
    if (waiting) begin
      cls_done  = (cyc - m_lc == m_lat);
      cls_class = cls_done ? m_dcls : 2'($urandom);
    end else begin
      cls_done  = spur && ($urandom_range(3) == 0);
      cls_class = 2'($urandom);
    end
    @(negedge clk);
    rv      = m_act && (m_rc >= 0) && (cyc >= m_rc);
    exp_rdy = (m_q.size() < DEPTH);
    chk("in_ready",  32'(in_ready),  32'(exp_rdy));
    chk("cls_start", 32'(cls_start), 32'(m_act && cyc == m_lc));
    chk("cls_x",     32'(cls_x),     32'(m_cx));
    chk("cls_y",     32'(cls_y),     32'(m_cy));
    chk("res_valid", 32'(res_valid), 32'(rv));
    chk("res_class", 32'(res_class), 32'(m_cls));
    chk("res_tag",   32'(res_tag),   32'(m_rtag));
    chk("res_err",   32'(res_err),   32'(m_err));
    chk("busy",      32'(busy),      32'(m_q.size() != 0 || m_act));
    if (cls_start === 1'b1) launch_log.push_back('{cls_x, cls_y, cyc});
    if (res_valid === 1'b1 && !prev_rv) res_log.push_back('{res_class, res_tag, res_err, cyc});
    prev_rv = (res_valid === 1'b1);
    // advance model to the next cycle
    if (waiting) begin
      if (cls_done) capture(cls_class, 1'b0);
      else if (cyc - m_lc == TIMEOUT) capture(2'd0, 1'b1);
    end
    if (rv && res_ready) begin m_act = 0; m_idle_from = cyc + 1; end
    if (!m_act && cyc >= m_idle_from && m_q.size() != 0) begin
      pr = m_q.pop_front();
      m_cx = pr[15:8]; m_cy = pr[7:0]; m_act = 1; m_lc = cyc + 1; m_rc = -1;
      m_lat  = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(TIMEOUT + 10, 1));
      m_dcls = (dcls_q.size() != 0) ? dcls_q.pop_front() : 2'($urandom);
    end
    if (in_valid && exp_rdy) begin
      void'(byte_q.pop_front());
      if (!m_phase) begin m_xh = in_data; m_phase = 1; end
      else begin m_q.push_back({m_xh, in_data}); m_phase = 0; end
    end
  endtask

  task automatic do_reset();
    #2;
    in_valid = 0; res_ready = 0; cls_done = 0;
    rst = 0;
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_cls_x",     32'(cls_x),     32'd0);
    chk("rst_cls_y",     32'(cls_y),     32'd0);
    chk("rst_cls_start", 32'(cls_start), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_class", 32'(res_class), 32'd0);
    chk("rst_res_tag",   32'(res_tag),   32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    byte_q.delete(); lat_q.delete(); dcls_q.delete();
    launch_log.delete(); res_log.delete();
    model_reset();
  endtask

  task automatic run_until_idle(input int budget);
    int b = 0;
    while (!(byte_q.size() == 0 && m_q.size() == 0 && !m_act && !m_phase) && b < budget) begin
      step(); b++;
    end
    if (b >= budget) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout cyc=%0d got=busy expected=idle within %0d cycles", cyc, budget);
    end
  endtask

  task automatic add_pairs(input int n);
    repeat (2 * n) byte_q.push_back(8'($urandom));
  endtask

  initial begin
    int b, nl;
    rst = 1; in_valid = 0; in_data = 0; res_ready = 0; cls_done = 0; cls_class = 0;
    model_reset();
    do_reset();

    // single query
    byte_q = '{8'hC6, 8'h7F}; lat_q = '{34}; dcls_q = '{2'd2};
    run_until_idle(200);
    chk("sq_launches", 32'(launch_log.size()), 32'd1);
    chk("sq_x", 32'(launch_log[0].x), 32'hC6);
    chk("sq_y", 32'(launch_log[0].y), 32'h7F);
    chk("sq_class", 32'(res_log[0].cls), 32'd2);
    chk("sq_tag", 32'(res_log[0].tag), 32'd0);
    chk("sq_err", 32'(res_log[0].err), 32'd0);
    chk("sq_latency", 32'(res_log[0].c - launch_log[0].c), 32'd35);

    // FIFO full: 6 pairs behind a slow first query
    do_reset();
    add_pairs(6); lat_q = '{30, 5, 5, 5, 5, 5};
    repeat (20) step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    run_until_idle(400);
    chk("full_results", 32'(res_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("full_tag_order", 32'(res_log[i].tag), 32'(i));

    // timeout followed by a normal query
    lat_q = '{TIMEOUT + 5, 7};
    launch_log.delete(); res_log.delete();
    add_pairs(2);
    run_until_idle(300);
    chk("to_err", 32'(res_log[0].err), 32'd1);
    chk("to_class", 32'(res_log[0].cls), 32'd0);
    chk("to_latency", 32'(res_log[0].c - launch_log[0].c), 32'(TIMEOUT + 1));
    chk("to_next_err", 32'(res_log[1].err), 32'd0);

    // done on the timeout cycle wins
    lat_q = '{TIMEOUT}; dcls_q = '{2'd1};
    launch_log.delete(); res_log.delete();
    add_pairs(1);
    run_until_idle(300);
    chk("col_err", 32'(res_log[0].err), 32'd0);
    chk("col_class", 32'(res_log[0].cls), 32'd1);
    chk("col_latency", 32'(res_log[0].c - launch_log[0].c), 32'(TIMEOUT + 1));

    // result back-pressure
    hold_ready = 1; lat_q = '{3, 3};
    add_pairs(2);
    b = 0;
    while (!(m_act && m_rc >= 0 && cyc >= m_rc) && b < 100) begin step(); b++; end
    if (b >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL bp_wait cyc=%0d got=no result expected=result within 100 cycles", cyc);
    end
    nl = launch_log.size();
    repeat (20) step();
    chk("bp_no_launch", 32'(launch_log.size()), 32'(nl));
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    hold_ready = 0;
    run_until_idle(300);

    // 17 queries with throttled handshakes: tag wraps
    do_reset();
    vprob = 60; rprob = 50; spur = 1;
    add_pairs(17);
    for (int i = 0; i < 17; i++) lat_q.push_back(int'($urandom_range(10, 1)));
    run_until_idle(2000);
    chk("wrap_results", 32'(res_log.size()), 32'd17);
    chk("wrap_tag15", 32'(res_log[15].tag), 32'd15);
    chk("wrap_tag0", 32'(res_log[16].tag), 32'd0);

    // random soak including timeouts
    add_pairs(30);
    run_until_idle(4000);

    // reset mid-WAIT with a half-received pair
    vprob = 100; rprob = 100; spur = 0;
    byte_q = '{8'h11, 8'h22, 8'h33}; lat_q = '{30};
    repeat (10) step();
    chk("mid_busy", 32'(busy), 32'd1);
    do_reset();
    byte_q = '{8'h10, 8'h20}; lat_q = '{4};
    run_until_idle(200);
    chk("post_rst_launches", 32'(launch_log.size()), 32'd1);
    chk("post_rst_x", 32'(launch_log[0].x), 32'h10);
    chk("post_rst_y", 32'(launch_log[0].y), 32'h20);
    chk("post_rst_tag", 32'(res_log[0].tag), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/knn_query_sequencer.md
Name: knn_query_sequencer

Overview:
Front-end stage placed directly upstream of the KNN classifier core. It receives query points as a byte stream (x byte, then y byte) and buffers them in a small FIFO. It launches one classification at a time by holding the query coordinates stable and pulsing start, waits for the core's done, and then presents the class on a valid/ready result port.
It replaces the fixed query constants with a streaming, back-pressured interface and adds a watchdog timeout.

Parameters:
DEPTH, 4, query FIFO depth in entries (power of two, 2..16); each entry is 16 bits {x,y}
TIMEOUT, 1023, max cycles to wait for cls_done after cls_start before declaring an error
TAG_W, 4, width of the per-query sequence tag

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  query byte valid
in_data  in  8  query byte; first byte of a pair = x, second = y
in_ready  out  1  byte accepted when in_valid && in_ready
cls_x  out  8  query x to classifier; held stable from cls_start until result capture
cls_y  out  8  query y to classifier; same stability rule as cls_x
cls_start  out  1  single-cycle launch pulse
cls_done  in  1  classifier result-valid strobe
cls_class  in  2  classifier predicted class, sampled when cls_done=1
res_valid  out  1  result available
res_ready  in  1  result consumer ready
res_class  out  2  captured class
res_tag  out  TAG_W  sequence tag of this query
res_err  out  1  1 = timeout, no class produced
busy  out  1  high in LAUNCH/WAIT/HOLD or when FIFO non-empty

Behaviour:
- Reset (rst=0, async): FIFO empty, byte phase=0, tag=0, FSM=IDLE.
- Reset values: in_ready=1; cls_x=0; cls_y=0; cls_start=0; res_valid=0; res_class=0; res_tag=0; res_err=0; busy=0.
- Byte assembly:
  - in_ready = !fifo_full (registered full flag).
  - Accepted byte with phase=0: store to x_hold, set phase=1.
  - Accepted byte with phase=1: push {x_hold,byte} into FIFO, set phase=0.
- FIFO: circular, pointers wrap at DEPTH, count 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - Push is never attempted when full, because in_ready is low.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head into cls_x/cls_y and go to LAUNCH.
  - LAUNCH: cls_start=1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT: wait counter increments each cycle.
    - cls_done=1: capture res_class=cls_class, res_err=0, res_tag=tag, res_valid=1, tag<=tag+1 (wraps at 2^TAG_W), go to HOLD.
    - Else if counter==TIMEOUT: res_class=0, res_err=1, res_valid=1, res_tag=tag, tag<=tag+1, go to HOLD.
    - cls_done in the same cycle as counter==TIMEOUT: done wins, res_err=0.
  - HOLD: res_valid, res_class, res_tag and res_err stay stable. When res_ready=1, clear res_valid and go to IDLE.
- cls_done outside WAIT is ignored. cls_x/cls_y change only in IDLE on a pop.
- Latency: the second byte is accepted at edge T. FIFO is non-empty after T. The pop happens at T+1, and cls_start is high in cycle T+1..T+2. Result is valid one cycle after the cls_done sample.
- Back-to-back queries: the earliest next cls_start is 2 cycles after the res_valid handshake (HOLD→IDLE→LAUNCH).
- Reset mid-operation: all state discarded, including a half-received pair and any pending result.

Optional Feature:
Macro KNN_QUERY_STATS_EN.
- Defined: adds outputs stat_count[15:0] (completed queries, saturating at 0xFFFF, counts errors too), stat_err[7:0] (timeouts, saturating) and stat_last_lat[9:0] (WAIT-cycle count of the most recent query, captured on the WAIT exit edge). All three reset to 0.
- Undefined: these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Single query: send bytes 0xC6,0x7F; classifier model asserts cls_done with class 2 after 34 WAIT cycles → cls_x=0xC6, cls_y=0x7F, one cls_start pulse; res_valid with res_class=2, res_tag=0, res_err=0; res_ready=1 clears it next edge.
- FIFO full: hold cls_done low, then stream 5 pairs with DEPTH=4 → one query in flight plus 4 buffered. in_ready drops after the 10th byte's push fills the FIFO; the 11th byte waits. Results come out in order with tags 0..4.
- Timeout: TIMEOUT=15, never assert cls_done → res_valid exactly 16 cycles after the cls_start cycle, with res_err=1, res_class=0. The next query then runs normally.
- Done/timeout collision: cls_done=1 with class 1 exactly on counter==TIMEOUT → res_err=0, res_class=1.
- Back-pressure and wrap: hold res_ready=0 for 20 cycles in HOLD → outputs stable and no new cls_start. Run 17 queries → res_tag sequence wraps 15→0.
- Async reset: assert rst=0 mid-WAIT and after one byte of a pair → all outputs at reset values immediately. After release, a fresh pair 0x10,0x20 yields cls_x=0x10, cls_y=0x20.
